// File: rtl/branch_commit_unit.sv
// Branch/jump resolution at commit. Carries {valid, pc, btb_hit} through the
// IF/ID, ID/EX and EX/MEM slots, resolves the EX instruction's outcome and
// target, registers it into EX/MEM for the predictor, and counts committed
// control-flow instructions and mispredictions.
module branch_commit_unit #(
  parameter int INDEX_WIDTH = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          IF_valid_i,
  input  logic [31:0]                   IF_pc_i,
  input  logic                          IF_btb_hit_i,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic                          EX_is_br_i,
  input  logic [1:0]                    EX_is_uncbr_i,
  input  logic [2:0]                    EX_funct3_i,
  input  logic [31:0]                   EX_rs1_i,
  input  logic [31:0]                   EX_rs2_i,
  input  logic [31:0]                   EX_imm_i,
  output logic                          EXMEM_is_br_o,
  output logic [1:0]                    EXMEM_is_uncbr_o,
  output logic                          EXMEM_btb_hit_o,
  output logic                          EXMEM_br_decision_o,
  output logic [INDEX_WIDTH-1:0]        EXMEM_btb_wr_index_o,
  output logic [32-INDEX_WIDTH-2-1:0]   EXMEM_btb_wr_tag_o,
  output logic [31:0]                   EXMEM_btb_wr_target_o,
  output logic [31:0]                   EXMEM_br_target_o,
  output logic [31:0]                   EXMEM_pc_plus4_o,
  output logic                          EXMEM_mispredict_o,
  output logic [31:0]                   br_count_o,
  output logic [31:0]                   mispredict_count_o
);

  // Branch condition evaluation; reserved codes 010/011 resolve not-taken.
  function automatic logic cond_taken(input logic [2:0] f3,
                                      input logic signed [31:0] a,
                                      input logic signed [31:0] b);
    logic r;
    case (f3)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b100:  r = (a < b);
      3'b101:  r = (a >= b);
      3'b110:  r = ($unsigned(a) < $unsigned(b));
      3'b111:  r = ($unsigned(a) >= $unsigned(b));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // 32-bit wrapping address add.
  function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  // IF/ID slot
  logic        vld_p0;
  logic [31:0] pc_p0;
  logic        hit_p0;
  // ID/EX slot
  logic        vld_p1;
  logic [31:0] pc_p1;
  logic        hit_p1;
  // EX/MEM slot
  logic        vld_p2;
  logic        is_br_p2;
  logic [1:0]  uncbr_p2;
  logic        hit_p2;
  logic        dec_p2;
  logic [31:0] pc_p2;
  logic [31:0] tgt_p2;
  logic [31:0] pc4_p2;
  logic        misp_p2;

  // EX-stage resolution results
  logic        ex_br, ex_jal, ex_jalr, ex_cf;
  logic        ex_is_br;
  logic [1:0]  ex_uncbr;
  logic        ex_hit, ex_dec, ex_misp;
  logic [31:0] ex_tgt, ex_pc4;

  // Resolve class, decision, target and mispredict for the ID/EX instruction.
  always_comb begin
    ex_br    = EX_is_br_i;
    ex_jal   = !EX_is_br_i && (EX_is_uncbr_i == 2'b10);
    ex_jalr  = !EX_is_br_i && (EX_is_uncbr_i == 2'b11);
    ex_cf    = vld_p1 && (ex_br || ex_jal || ex_jalr);
    ex_is_br = 1'b0;
    ex_uncbr = 2'b00;
    ex_hit   = 1'b0;
    ex_dec   = 1'b0;
    ex_tgt   = 32'd0;
    ex_misp  = 1'b0;
    ex_pc4   = vld_p1 ? wrap_add(pc_p1, 32'd4) : 32'd0;
    if (ex_cf) begin
      ex_is_br = ex_br;
      ex_uncbr = ex_br ? 2'b00 : EX_is_uncbr_i;
      ex_hit   = hit_p1;
      ex_dec   = ex_br ? cond_taken(EX_funct3_i, EX_rs1_i, EX_rs2_i) : 1'b1;
      ex_tgt   = ex_jalr ? (wrap_add(EX_rs1_i, EX_imm_i) & ~32'd1)
                         : wrap_add(pc_p1, EX_imm_i);
      ex_misp  = ex_jalr ? 1'b1 : (hit_p1 ^ ex_dec);
    end
  end

  // Slot pipeline: reset > flush > stall > shift.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_p0   <= 1'b0;
      pc_p0    <= 32'd0;
      hit_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      pc_p1    <= 32'd0;
      hit_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      is_br_p2 <= 1'b0;
      uncbr_p2 <= 2'b00;
      hit_p2   <= 1'b0;
      dec_p2   <= 1'b0;
      pc_p2    <= 32'd0;
      tgt_p2   <= 32'd0;
      pc4_p2   <= 32'd0;
      misp_p2  <= 1'b0;
    end else begin
      // IF -> IF/ID (held on stall; invalid fetches become clean bubbles)
      if (!stall_i) begin
        vld_p0 <= IF_valid_i;
        pc_p0  <= IF_valid_i ? IF_pc_i : 32'd0;
        hit_p0 <= IF_valid_i && IF_btb_hit_i;
      end
      // IF/ID -> ID/EX (bubble on stall)
      if (stall_i) begin
        vld_p1 <= 1'b0;
        pc_p1  <= 32'd0;
        hit_p1 <= 1'b0;
      end else begin
        vld_p1 <= vld_p0;
        pc_p1  <= pc_p0;
        hit_p1 <= hit_p0;
      end
      // ID/EX -> EX/MEM (always advances)
      vld_p2   <= vld_p1;
      is_br_p2 <= ex_is_br;
      uncbr_p2 <= ex_uncbr;
      hit_p2   <= ex_hit;
      dec_p2   <= ex_dec;
      pc_p2    <= pc_p1;
      tgt_p2   <= ex_tgt;
      pc4_p2   <= ex_pc4;
      misp_p2  <= ex_misp;
    end
  end

  // Performance counters sample the EX/MEM slot, lagging it by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_count_o         <= 32'd0;
      mispredict_count_o <= 32'd0;
    end else begin
      if (vld_p2 && (is_br_p2 || uncbr_p2[1])) br_count_o <= br_count_o + 32'd1;
      if (vld_p2 && misp_p2) mispredict_count_o <= mispredict_count_o + 32'd1;
    end
  end

  assign EXMEM_is_br_o         = is_br_p2;
  assign EXMEM_is_uncbr_o      = uncbr_p2;
  assign EXMEM_btb_hit_o       = hit_p2;
  assign EXMEM_br_decision_o   = dec_p2;
  assign EXMEM_btb_wr_index_o  = pc_p2[INDEX_WIDTH+1:2];
  assign EXMEM_btb_wr_tag_o    = pc_p2[31:INDEX_WIDTH+2];
  assign EXMEM_btb_wr_target_o = tgt_p2;
  assign EXMEM_br_target_o     = tgt_p2;
  assign EXMEM_pc_plus4_o      = pc4_p2;
  assign EXMEM_mispredict_o    = misp_p2;

endmodule

// File: tb/tb_branch_commit_unit.sv
// Testbench for branch_commit_unit: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_branch_commit_unit;
  localparam int IW = 12;
  localparam int TW = 32 - IW - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic          if_hit;
  logic          stall;
  logic          flush;
  logic          ex_is_br;
  logic [1:0]    ex_uncbr;
  logic [2:0]    ex_f3;
  logic [31:0]   ex_rs1, ex_rs2, ex_imm;
  logic          o_is_br;
  logic [1:0]    o_uncbr;
  logic          o_hit, o_dec, o_misp;
  logic [IW-1:0] o_idx;
  logic [TW-1:0] o_tag;
  logic [31:0]   o_wtgt, o_tgt, o_p4, o_brc, o_mpc;

  branch_commit_unit #(.INDEX_WIDTH(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .IF_valid_i(if_valid), .IF_pc_i(if_pc), .IF_btb_hit_i(if_hit),
    .stall_i(stall), .flush_i(flush),
    .EX_is_br_i(ex_is_br), .EX_is_uncbr_i(ex_uncbr), .EX_funct3_i(ex_f3),
    .EX_rs1_i(ex_rs1), .EX_rs2_i(ex_rs2), .EX_imm_i(ex_imm),
    .EXMEM_is_br_o(o_is_br), .EXMEM_is_uncbr_o(o_uncbr),
    .EXMEM_btb_hit_o(o_hit), .EXMEM_br_decision_o(o_dec),
    .EXMEM_btb_wr_index_o(o_idx), .EXMEM_btb_wr_tag_o(o_tag),
    .EXMEM_btb_wr_target_o(o_wtgt), .EXMEM_br_target_o(o_tgt),
    .EXMEM_pc_plus4_o(o_p4), .EXMEM_mispredict_o(o_misp),
    .br_count_o(o_brc), .mispredict_count_o(o_mpc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        hit;
  } slot_t;

  typedef struct {
    logic        is_br;
    logic [1:0]  unc;
    logic        hit;
    logic        dec;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] p4;
    logic        misp;
  } res_t;

  int vectors = 0;
  int miscompares = 0;

  slot_t       m_ifid, m_idex;
  res_t        m_exm;
  int unsigned m_brc, m_mpc;

  function automatic slot_t bubble();
    slot_t s;
    s.v = 1'b0; s.pc = 32'd0; s.hit = 1'b0;
    return s;
  endfunction

  function automatic res_t empty_res();
    res_t r;
    r.is_br = 0; r.unc = 0; r.hit = 0; r.dec = 0;
    r.pc = 0; r.tgt = 0; r.p4 = 0; r.misp = 0;
    return r;
  endfunction

  // Outcome of one instruction, straight from the architectural rules.
  function automatic res_t resolve(slot_t s, logic br, logic [1:0] unc, logic [2:0] f3,
                                   logic [31:0] a, logic [31:0] b, logic [31:0] imm);
    res_t   r;
    longint sa, sb, ua, ub;
    string  kind;
    r = empty_res();
    if (!s.v) return r;
    r.pc = s.pc;
    r.p4 = 32'((longint'(s.pc) + 4) % 64'h1_0000_0000);
    if (br) kind = "br";
    else if (unc == 2'b10) kind = "jal";
    else if (unc == 2'b11) kind = "jalr";
    else kind = "none";
    if (kind == "none") return r;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    r.hit = s.hit;
    if (kind == "br") begin
      r.is_br = 1;
      case (f3)
        3'd0: r.dec = (ua == ub);
        3'd1: r.dec = (ua != ub);
        3'd4: r.dec = (sa < sb);
        3'd5: r.dec = (sa >= sb);
        3'd6: r.dec = (ua < ub);
        3'd7: r.dec = (ua >= ub);
        default: r.dec = 0;
      endcase
    end else begin
      r.unc = unc;
      r.dec = 1;
    end
    if (kind == "jalr") begin
      r.tgt  = 32'((ua + longint'(imm)) % 64'h1_0000_0000);
      r.tgt  = r.tgt - (r.tgt % 2);
      r.misp = 1;
    end else begin
      r.tgt  = 32'((longint'(s.pc) + longint'(imm)) % 64'h1_0000_0000);
      r.misp = (r.hit != r.dec);
    end
    return r;
  endfunction

  function automatic logic [131:0] pack_res(res_t r);
    logic [31:0] idx, tag;
    idx = (r.pc / 4) % (32'd1 << IW);
    tag = r.pc / (32'd1 << (IW + 2));
    return {r.is_br, r.unc, r.hit, r.dec, idx[IW-1:0], tag[TW-1:0], r.tgt, r.tgt, r.p4, r.misp};
  endfunction

  function automatic logic [131:0] dut_vec();
    return {o_is_br, o_uncbr, o_hit, o_dec, o_idx, o_tag, o_wtgt, o_tgt, o_p4, o_misp};
  endfunction

  task automatic chk(string tag, logic [131:0] obs, logic [131:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic cycle(string tag);
    slot_t n_ifid, n_idex;
    res_t  n_exm;
    int unsigned n_brc, n_mpc;
    n_brc = m_brc; n_mpc = m_mpc;
    if (m_exm.is_br || m_exm.unc[1]) n_brc = m_brc + 1;
    if (m_exm.misp) n_mpc = m_mpc + 1;
    n_ifid = m_ifid; n_idex = m_idex; n_exm = m_exm;
    if (rst) begin
      n_ifid = bubble(); n_idex = bubble(); n_exm = empty_res(); n_brc = 0; n_mpc = 0;
    end else if (flush) begin
      n_ifid = bubble(); n_idex = bubble(); n_exm = empty_res();
    end else begin
      n_exm = resolve(m_idex, ex_is_br, ex_uncbr, ex_f3, ex_rs1, ex_rs2, ex_imm);
      if (stall) n_idex = bubble();
      else begin
        n_idex = m_ifid;
        if (if_valid) begin n_ifid.v = 1; n_ifid.pc = if_pc; n_ifid.hit = if_hit; end
        else n_ifid = bubble();
      end
    end
    @(posedge clk); #1;
    m_ifid = n_ifid; m_idex = n_idex; m_exm = n_exm; m_brc = n_brc; m_mpc = n_mpc;
    chk({tag, "_exmem"}, dut_vec(), pack_res(m_exm));
    chk({tag, "_counts"}, {68'd0, o_brc, o_mpc}, {68'd0, m_brc, m_mpc});
  endtask

  task automatic idle_inputs();
    rst = 0; if_valid = 0; if_pc = 0; if_hit = 0; stall = 0; flush = 0;
    ex_is_br = 0; ex_uncbr = 0; ex_f3 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_imm = 0;
  endtask

  task automatic rand_inputs();
    if_valid = 1'($urandom); if_pc = $urandom; if_hit = 1'($urandom);
    ex_is_br = ($urandom_range(0, 9) < 3); ex_uncbr = 2'($urandom);
    ex_f3 = 3'($urandom); ex_imm = $urandom;
    ex_rs1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    ex_rs2 = ($urandom_range(0, 3) == 0) ? ex_rs1 : $urandom;
  endtask

  // Fetch one instruction, let it reach ID/EX, resolve it, land in EX/MEM.
  task automatic run_one(string tag, logic [31:0] pc, logic hit, logic br, logic [1:0] unc,
                         logic [2:0] f3, logic [31:0] a, logic [31:0] b, logic [31:0] imm);
    idle_inputs();
    if_valid = 1; if_pc = pc; if_hit = hit;
    cycle({tag, "_if"});
    idle_inputs();
    cycle({tag, "_id"});
    ex_is_br = br; ex_uncbr = unc; ex_f3 = f3; ex_rs1 = a; ex_rs2 = b; ex_imm = imm;
    cycle({tag, "_ex"});
    idle_inputs();
  endtask

  task automatic chk_bit(string tag, logic obs, logic exp);
    chk(tag, {131'd0, obs}, {131'd0, exp});
  endtask

  task automatic chk_word(string tag, logic [31:0] obs, logic [31:0] exp);
    chk(tag, {100'd0, obs}, {100'd0, exp});
  endtask

  typedef struct {
    logic [31:0] pc; logic hit; logic br; logic [1:0] unc;
    logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] imm;
  } instr_t;

  instr_t      tbl[5];
  logic [31:0] save_brc, save_mpc;

  initial begin
    m_ifid = bubble(); m_idex = bubble(); m_exm = empty_res(); m_brc = 0; m_mpc = 0;

    // Reset with random inputs for two cycles
    rand_inputs(); stall = 0; flush = 0; rst = 1;
    cycle("reset0");
    rand_inputs(); rst = 1;
    cycle("reset1");
    chk("reset_all_zero", {dut_vec(), o_brc, o_mpc}, '0);
    idle_inputs();

    // BEQ taken, BTB miss
    run_one("beq", 32'h100, 0, 1, 2'b00, 3'b000, 32'd5, 32'd5, 32'h40);
    chk_bit("beq_dec", o_dec, 1);
    chk_word("beq_tgt", o_tgt, 32'h140);
    chk_word("beq_p4", o_p4, 32'h104);
    chk_word("beq_idx", {20'd0, o_idx}, 32'h040);
    chk_word("beq_tag", {14'd0, o_tag}, 32'h0);
    chk_bit("beq_misp", o_misp, 1);

    // Signed vs unsigned less-than
    run_one("blt", 32'h200, 1, 1, 2'b00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h10);
    chk_bit("blt_dec", o_dec, 1);
    chk_bit("blt_misp", o_misp, 0);
    run_one("bltu", 32'h200, 1, 1, 2'b00, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h10);
    chk_bit("bltu_dec", o_dec, 0);
    chk_bit("bltu_misp", o_misp, 1);

    // JALR clears bit 0 and always mispredicts
    run_one("jalr", 32'h300, 1, 0, 2'b11, 3'b000, 32'h2001, 32'd0, 32'd4);
    chk_word("jalr_tgt", o_tgt, 32'h2004);
    chk_bit("jalr_dec", o_dec, 1);
    chk_bit("jalr_misp", o_misp, 1);

    // One-cycle stall with a branch in IF/ID
    idle_inputs(); if_valid = 1; if_pc = 32'h400; if_hit = 1;
    cycle("stall_if");
    idle_inputs(); stall = 1; if_valid = 1; if_pc = 32'h999;
    cycle("stall_hold");
    idle_inputs();
    cycle("stall_id");
    chk("stall_bubble", dut_vec(), '0);
    ex_is_br = 1; ex_f3 = 3'b000; ex_rs1 = 7; ex_rs2 = 7; ex_imm = 32'h20;
    cycle("stall_ex");
    chk_word("stall_tgt", o_tgt, 32'h420);
    chk_bit("stall_misp", o_misp, 0);
    idle_inputs();
    cycle("stall_drain");

    // Flush with branches in IF/ID and ID/EX
    save_brc = o_brc; save_mpc = o_mpc;
    idle_inputs(); if_valid = 1; if_pc = 32'h500; if_hit = 0;
    cycle("flush_a");
    if_pc = 32'h504;
    cycle("flush_b");
    ex_is_br = 1; ex_f3 = 3'b000; if_pc = 32'h508; flush = 1;
    cycle("flush_go");
    idle_inputs(); ex_is_br = 1;
    for (int i = 0; i < 3; i++) begin
      cycle("flush_drain");
      chk("flush_bubble", dut_vec(), '0);
    end
    chk("flush_counts", {68'd0, o_brc, o_mpc}, {68'd0, save_brc, save_mpc});

    // Counters: 3 branches (1 mispredicted) + 2 non-branch instructions
    idle_inputs(); rst = 1;
    cycle("cnt_rst");
    tbl[0] = '{32'h600, 1, 1, 2'b00, 3'b000, 32'd3, 32'd3, 32'h8};
    tbl[1] = '{32'h604, 0, 0, 2'b00, 3'b000, 32'd0, 32'd0, 32'h0};
    tbl[2] = '{32'h608, 0, 1, 2'b00, 3'b001, 32'd9, 32'd9, 32'h8};
    tbl[3] = '{32'h60C, 1, 0, 2'b01, 3'b000, 32'd0, 32'd0, 32'h0};
    tbl[4] = '{32'h610, 1, 1, 2'b00, 3'b101, 32'd1, 32'd2, 32'h8};
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c < 5) begin if_valid = 1; if_pc = tbl[c].pc; if_hit = tbl[c].hit; end
      if (c >= 2 && c < 7) begin
        ex_is_br = tbl[c-2].br; ex_uncbr = tbl[c-2].unc; ex_f3 = tbl[c-2].f3;
        ex_rs1 = tbl[c-2].a; ex_rs2 = tbl[c-2].b; ex_imm = tbl[c-2].imm;
      end
      cycle("cnt_seq");
    end
    chk_word("cnt_br", o_brc, 32'd3);
    chk_word("cnt_misp", o_mpc, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
